freq_div_prog: RTL and testbench
================================

Name: freq_div_prog

Overview:
- Runtime-programmable integer clock divider: successor to the fixed divide-by-2 stage.
- Divides `clk` by any N in 2..2^WIDTH-1 with 50% duty cycle for both even and odd N. Odd N uses a half-cycle negedge stage.
- Divisor updates are glitch-free: a new divisor takes effect only at an output period boundary.
- Provides enable and a period tick. Used to derive slow clocks/strobes from the system clock.

Parameters:
- WIDTH, 8, width of divisor, counter and status.
- DEFAULT_DIV, 2, divisor in force after reset. Values <2 are clamped to 2.

Ports:
- clk  input  1  system clock; all state on posedge except the odd-duty stage (negedge).
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable, sampled on posedge.
- load  input  1  one-cycle strobe; captures div_val into pending register.
- div_val  input  WIDTH  requested divisor N.
- out_clk  output  1  divided clock.
- tick  output  1  one-clk-cycle pulse coincident with each out_clk period start.
- cur_div  output  WIDTH  divisor currently in force.

Behaviour:
- Reset (async, rst=1), effective immediately:
  - state=IDLE, cnt=0, p=0, n=0, tick=0, out_clk=0.
  - cur_div=pending=max(DEFAULT_DIV,2); pend_valid=0.
- Divisor clamp: any div_val of 0 or 1 is stored as 2. No bypass mode.
- load: on posedge with load=1, pending<=clamp(div_val), pend_valid<=1.
  - Repeated loads before application: the last one wins.
  - load and an application edge in the same cycle: the new value goes to pending and applies at the next boundary.
- Let N=cur_div and H=ceil(N/2).
- FSM IDLE:
  - Outputs held low.
  - If pend_valid: cur_div<=pending, pend_valid<=0 (immediate apply while stopped).
  - On posedge with en=1: go to RUN, cnt<=0, p<=1, tick<=1. Apply pending first if valid, so the first period uses the newest divisor.
- FSM RUN, each posedge:
  - If en=0: go to IDLE, cnt<=0, p<=0, tick<=0. out_clk falls at this edge even mid-high-phase, giving a truncated final pulse. This is accepted.
  - Otherwise, if cnt==N-1 (wrap):
    - If pend_valid, apply pending (cur_div<=pending, pend_valid<=0); the new N/H govern the new period.
    - cnt<=0, p<=1, tick<=1.
  - Otherwise: cnt<=cnt+1, p<=(cnt+1<H), tick<=0.
- Odd-duty stage: n samples p on negedge clk (async reset to 0).
- Output:
  - Even N: out_clk=p.
  - Odd N: out_clk=p&n.
  - Even: high N/2 cycles, low N/2.
  - Odd: rise delayed 0.5 cycle after p rises, fall with p, so high time = N/2 cycles exactly.
  - Selection uses the LSB of cur_div. cur_div only changes at a period boundary where p rises and n is still 0, so no glitch.
- Latency: first out_clk rise occurs at the first posedge sampling en=1 (even N), or half a cycle later (odd N). tick rises at that same posedge.
- Period: exactly N clk cycles between consecutive tick pulses while en stays high.
- Reset mid-operation: all outputs go to their reset values asynchronously. Counting resumes only via IDLE→RUN after rst deasserts and en=1.

Test Plan:
- Reset, en=1, no load → cur_div=2; out_clk toggles every posedge (period 2); tick every 2nd cycle; first rise on first enabled edge.
- load div_val=3 while idle, en=1 → period 3 cycles; out_clk high exactly 1.5 cycles (rise at negedge, fall at posedge); tick every 3 cycles.
- Running N=4, load div_val=7 at cnt=1 → current period completes as 4 cycles (high 2/low 2); next period is 7 cycles, high 3.5; cur_div changes to 7 only at the wrap edge.
- load div_val=0, then div_val=1 → cur_div=2; period 2, never passes clk through.
- Running N=6, drop en at cnt=4 → IDLE; out_clk=0 and tick=0 from that edge. Re-raise en → fresh period starting at cnt=0 with tick.
- N=5 running, assert rst asynchronously mid-high-phase → out_clk, tick and cnt go to 0 immediately; cur_div=DEFAULT_DIV; pending load discarded.

Source files
------------

// File: rtl/freq_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
// Master drives enable/load/divisor; slave returns the divided clock, tick and active divisor.
interface freq_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_val;
    logic             out_clk;
    logic             tick;
    logic [WIDTH-1:0] cur_div;

    modport master (
        output en, load, div_val,
        input  out_clk, tick, cur_div
    );

    modport slave (
        input  en, load, div_val,
        output out_clk, tick, cur_div
    );
endinterface

// File: rtl/freq_div_prog.sv
// Runtime-programmable integer clock divider, 50% duty for even and odd N.
// New divisors apply only at a period boundary, or immediately while stopped.
module freq_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    freq_div_prog_if.slave       bus
);
    localparam int               DEF_CLAMPED = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [WIDTH-1:0] DEF_DIV     = DEF_CLAMPED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO         = {{(WIDTH-2){1'b0}}, 2'b10};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] cur_div, cur_div_nxt;
    logic [WIDTH-1:0] pending, pending_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic             p, p_nxt;
    logic             tick, tick_nxt;
    logic             n;

    logic [WIDTH:0]   half;
    logic [WIDTH:0]   cnt_inc;
    logic [WIDTH-1:0] load_val;
    logic             wrap;

    assign half     = ({1'b0, cur_div} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    assign cnt_inc  = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign wrap     = (cnt == (cur_div - ONE));
    assign load_val = (bus.div_val[WIDTH-1:1] == '0) ? TWO : bus.div_val;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        cur_div_nxt    = cur_div;
        pending_nxt    = pending;
        pend_valid_nxt = pend_valid;
        p_nxt          = p;
        tick_nxt       = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                p_nxt   = 1'b0;
                if (pend_valid) begin
                    cur_div_nxt    = pending;
                    pend_valid_nxt = 1'b0;
                end
                if (bus.en) begin
                    state_nxt = RUN;
                    p_nxt     = 1'b1;
                    tick_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    p_nxt     = 1'b0;
                end else if (wrap) begin
                    if (pend_valid) begin
                        cur_div_nxt    = pending;
                        pend_valid_nxt = 1'b0;
                    end
                    cnt_nxt  = '0;
                    p_nxt    = 1'b1;
                    tick_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc[WIDTH-1:0];
                    p_nxt   = (cnt_inc < half);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A load in the same cycle as an apply lands in pending for the next boundary.
        if (bus.load) begin
            pending_nxt    = load_val;
            pend_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_div    <= DEF_DIV;
            pending    <= DEF_DIV;
            pend_valid <= 1'b0;
            p          <= 1'b0;
            tick       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cur_div    <= cur_div_nxt;
            pending    <= pending_nxt;
            pend_valid <= pend_valid_nxt;
            p          <= p_nxt;
            tick       <= tick_nxt;
        end
    end

    // Half-cycle delayed copy of p; ANDing it in trims the odd-N high phase to N/2 cycles.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            n <= 1'b0;
        end else begin
            n <= p;
        end
    end

    assign bus.out_clk = cur_div[0] ? (p & n) : p;
    assign bus.tick    = tick;
    assign bus.cur_div = cur_div;
endmodule

// File: tb/tb_freq_div_prog.sv
// Bench for freq_div_prog: half-cycle reference model plus directed literal checks.
module tb_freq_div_prog;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   tick_seen   = 0;
    int   t0;

    freq_div_prog_if #(.WIDTH(WIDTH)) bus ();

    freq_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: running flag, cycle index within the period, divisor in force.
    bit m_run;
    int m_k;
    int m_n;
    int m_pend;
    bit m_pv;

    function automatic int clamp(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_k    = 0;
        m_n    = 2;
        m_pend = 2;
        m_pv   = 1'b0;
    endtask

    task automatic model_step();
        if (!m_run) begin
            if (m_pv) begin
                m_n  = m_pend;
                m_pv = 1'b0;
            end
            if (bus.en) begin
                m_run = 1'b1;
                m_k   = 0;
            end
        end else if (!bus.en) begin
            m_run = 1'b0;
            m_k   = 0;
        end else if (m_k == m_n - 1) begin
            if (m_pv) begin
                m_n  = m_pend;
                m_pv = 1'b0;
            end
            m_k = 0;
        end else begin
            m_k++;
        end
        if (bus.load) begin
            m_pend = clamp(int'(bus.div_val));
            m_pv   = 1'b1;
        end
    endtask

    // Expected output from the half-cycle position h within a 2N-half-cycle period:
    // even N is high for h in [0,N), odd N is high for h in [1,N].
    task automatic compare(input int half_phase);
        int h;
        bit exp_out;
        bit exp_tick;
        if (rst) model_reset();
        h        = 2 * m_k + half_phase;
        exp_out  = m_run && (((m_n % 2) == 0) ? (h < m_n) : (h >= 1 && h <= m_n));
        exp_tick = m_run && (m_k == 0);
        check("out_clk", int'(bus.out_clk), int'(exp_out));
        check("tick",    int'(bus.tick),    int'(exp_tick));
        check("cur_div", int'(bus.cur_div), m_n);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
            #1;
            compare(0);
            @(negedge clk);
            #1;
            compare(1);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.tick) tick_seen++;
        end
    end

    task automatic drive_wait(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            #3;
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.load    = 1'b0;
        bus.div_val = '0;
        drive_wait(2);
        rst = 1'b0;
        check("reset_cur_div", int'(bus.cur_div), 2);
        check("reset_out_clk", int'(bus.out_clk), 0);
        check("reset_tick",    int'(bus.tick),    0);
        drive_wait(1);

        // Default N=2: first rise and tick on the first enabled edge, 5 ticks in 10 cycles.
        t0     = tick_seen;
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        check("n2_first_rise", int'(bus.out_clk), 1);
        check("n2_first_tick", int'(bus.tick),    1);
        drive_wait(10);
        check("n2_tick_count", tick_seen - t0, 5);
        bus.en = 1'b0;
        drive_wait(2);

        // N=3 loaded while idle: rise delayed to the negedge, 3 ticks in 9 cycles.
        bus.load    = 1'b1;
        bus.div_val = 8'd3;
        drive_wait(1);
        bus.load = 1'b0;
        check("n3_not_yet", int'(bus.cur_div), 2);
        t0     = tick_seen;
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        check("n3_low_at_edge",  int'(bus.out_clk), 0);
        check("n3_tick",         int'(bus.tick),    1);
        check("n3_cur_div",      int'(bus.cur_div), 3);
        @(negedge clk);
        #1;
        check("n3_high_at_neg", int'(bus.out_clk), 1);
        drive_wait(8);
        check("n3_tick_count", tick_seen - t0, 3);
        bus.en = 1'b0;
        drive_wait(1);

        // N=4 running, load 7 with cnt=1: current period stays 4, then 7.
        bus.load    = 1'b1;
        bus.div_val = 8'd4;
        drive_wait(1);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        drive_wait(2);
        bus.load    = 1'b1;
        bus.div_val = 8'd7;
        drive_wait(1);
        bus.load = 1'b0;
        check("n4_hold_a", int'(bus.cur_div), 4);
        drive_wait(1);
        check("n4_hold_b", int'(bus.cur_div), 4);
        drive_wait(1);
        check("n7_applied", int'(bus.cur_div), 7);
        t0 = tick_seen;
        drive_wait(14);
        check("n7_tick_count", tick_seen - t0, 2);

        // Loads of 0 then 1 while running clamp to 2.
        bus.load    = 1'b1;
        bus.div_val = 8'd0;
        drive_wait(1);
        bus.div_val = 8'd1;
        drive_wait(1);
        bus.load = 1'b0;
        drive_wait(16);
        check("clamp_cur_div", int'(bus.cur_div), 2);
        t0 = tick_seen;
        drive_wait(10);
        check("clamp_tick_count", tick_seen - t0, 5);

        // N=6, drop en at cnt=4, then restart with a fresh tick.
        bus.en      = 1'b0;
        bus.load    = 1'b1;
        bus.div_val = 8'd6;
        drive_wait(1);
        bus.load = 1'b0;
        drive_wait(1);
        check("n6_idle_apply", int'(bus.cur_div), 6);
        bus.en = 1'b1;
        drive_wait(5);
        bus.en = 1'b0;
        drive_wait(1);
        check("n6_stop_out",  int'(bus.out_clk), 0);
        check("n6_stop_tick", int'(bus.tick),    0);
        drive_wait(2);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        check("n6_restart_tick", int'(bus.tick),    1);
        check("n6_restart_out",  int'(bus.out_clk), 1);
        drive_wait(8);

        // N=5, async reset in the high phase with a load pending.
        bus.en = 1'b0;
        drive_wait(1);
        bus.load    = 1'b1;
        bus.div_val = 8'd5;
        drive_wait(1);
        bus.load = 1'b0;
        drive_wait(1);
        bus.en = 1'b1;
        drive_wait(1);
        bus.load    = 1'b1;
        bus.div_val = 8'd9;
        drive_wait(1);
        bus.load = 1'b0;
        check("n5_high_before_rst", int'(bus.out_clk), 1);
        rst = 1'b1;
        #1;
        check("rst_async_out",     int'(bus.out_clk), 0);
        check("rst_async_tick",    int'(bus.tick),    0);
        check("rst_async_cur_div", int'(bus.cur_div), 2);
        drive_wait(2);
        rst = 1'b0;
        drive_wait(1);
        check("rst_pending_dropped", int'(bus.cur_div), 2);
        drive_wait(8);
        check("rst_still_default", int'(bus.cur_div), 2);
        bus.en = 1'b0;
        drive_wait(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
